// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the IF/LS memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LS   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between fetch and load/store; LS wins unless the optional
// anti-starvation counter (MEM_ARB_FAIRNESS_EN) forces a fetch grant.
module mem_arb_prio #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic async_rst_n,
    input  logic if_req,
    input  logic ls_req,
    input  logic flush,
    output logic if_gnt,
    output logic ls_gnt
);

    logic forceIf;

`ifdef MEM_ARB_FAIRNESS_EN
    logic [3:0] starveCnt_q;
    logic [3:0] starveCnt_d;

    assign forceIf = if_req && !flush && (starveCnt_q == 4'(STARVE_LIMIT));

    // Saturates at the limit so a flush-blocked forced cycle is retried next cycle.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (if_gnt || !if_req) begin
            starveCnt_d = 4'd0;
        end else if (ls_gnt && (starveCnt_q != 4'(STARVE_LIMIT))) begin
            starveCnt_d = starveCnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            starveCnt_q <= 4'd0;
        end else begin
            starveCnt_q <= starveCnt_d;
        end
    end
`else
    logic unusedPrio;

    assign forceIf    = 1'b0;
    assign unusedPrio = ^{clk, 4'(STARVE_LIMIT)};
`endif

    assign ls_gnt = async_rst_n && ls_req && !forceIf;
    assign if_gnt = async_rst_n && if_req && !flush && !ls_gnt;

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single-port RAM between fetch and load/store; registers the RAM
// command and steers read data back by owner. Fairness via MEM_ARB_FAIRNESS_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              async_rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              flush,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              memRe_q,    memRe_d;
    logic              memWe_q,    memWe_d;
    logic [ADDR_W-1:0] memAddr_q,  memAddr_d;
    logic [DATA_W-1:0] memWdata_q, memWdata_d;
    owner_t            stage0_q,   stage0_d;
    owner_t            stage1_q,   stage1_d;

    mem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .if_req      (if_req),
        .ls_req      (ls_req),
        .flush       (flush),
        .if_gnt      (if_gnt),
        .ls_gnt      (ls_gnt)
    );

    // Stores never enter the owner pipeline; a flush kills a fetch read in stage0.
    always_comb begin
        memRe_d    = 1'b0;
        memWe_d    = 1'b0;
        memAddr_d  = memAddr_q;
        memWdata_d = memWdata_q;
        stage0_d   = OWN_NONE;
        if (ls_gnt) begin
            memAddr_d = ls_addr;
            if (ls_we) begin
                memWe_d    = 1'b1;
                memWdata_d = ls_wdata;
            end else begin
                memRe_d  = 1'b1;
                stage0_d = OWN_LS;
            end
        end else if (if_gnt) begin
            memRe_d   = 1'b1;
            memAddr_d = if_addr;
            stage0_d  = OWN_IF;
        end
        stage1_d = (flush && (stage0_q == OWN_IF)) ? OWN_NONE : stage0_q;
    end

    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            memRe_q    <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            stage0_q   <= OWN_NONE;
            stage1_q   <= OWN_NONE;
        end else begin
            memRe_q    <= memRe_d;
            memWe_q    <= memWe_d;
            memAddr_q  <= memAddr_d;
            memWdata_q <= memWdata_d;
            stage0_q   <= stage0_d;
            stage1_q   <= stage1_d;
        end
    end

    assign mem_re    = memRe_q;
    assign mem_we    = memWe_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;

    // A flush arriving in the response cycle still suppresses the fetch data.
    assign if_rvalid = (stage1_q == OWN_IF) && !flush;
    assign ls_rvalid = (stage1_q == OWN_LS);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign ls_rdata  = ls_rvalid ? mem_rdata : '0;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares the single-port 8-bit RAM between instruction fetch (IF) and the load/store path (LS). It sits between the `fetch` stage, the execute-side load/store unit, and `memory`, and owns every RAM command. It issues at most one RAM access per cycle, registers the command, tracks which requester owns each in-flight read, and steers read data back with a valid pulse. LS has priority, bounded by an optional anti-starvation counter; a branch flush cancels in-flight fetch reads.

## Interface
Parameters:
- `STARVE_LIMIT`, 4: consecutive LS grants allowed while `if_req` is pending before IF is forced (range 1–15).

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `async_rst_n` in 1: asynchronous, active-low reset.
- `if_req` in 1: fetch read request; held with `if_addr` stable until `if_gnt`.
- `if_addr` in 8: fetch address (PC).
- `if_gnt` out 1: combinational; request accepted this cycle.
- `if_rvalid` out 1: `if_rdata` valid this cycle.
- `if_rdata` out 8: fetched word.
- `flush` in 1: branch taken; cancel in-flight fetch reads.
- `ls_req` in 1: load/store request; held stable until `ls_gnt`.
- `ls_we` in 1: 1 = store, 0 = load.
- `ls_addr` in 8: data address.
- `ls_wdata` in 8: store data.
- `ls_gnt` out 1: combinational; request accepted this cycle.
- `ls_rvalid` out 1: load data valid this cycle.
- `ls_rdata` out 8: load data.
- `mem_re` out 1: registered RAM read enable.
- `mem_we` out 1: registered RAM write enable.
- `mem_addr` out 8: registered RAM address.
- `mem_wdata` out 8: registered RAM write data.
- `mem_rdata` in 8: RAM read data, valid one cycle after `mem_re`.

## Operation
- Grant (at most one per cycle): `ls_req` wins unless starvation forcing applies; otherwise `if_req` is granted. `if_req` is never granted in a cycle where `flush`=1.
- On a grant, the command is latched into `mem_*` the next edge. With no grant, `mem_re`=`mem_we`=0. `mem_addr`/`mem_wdata` hold their last value.
- Owner pipeline: a 2-stage shift of owner (NONE/IF/LS). Stage0 is loaded at grant (NONE for stores). Stage1 follows stage0. `*_rvalid` is asserted when stage1 matches the owner. `*_rdata` = `mem_rdata` (zero when not valid).
- Stores produce no rvalid. They complete at grant from the requester's view.
- Flush: any IF entry in stage0 or stage1 is rewritten to NONE on the same edge. Its data is discarded and no `if_rvalid` is produced. LS entries are unaffected.
- Ordering: accesses reach RAM in grant order, so a store followed by a load to the same address returns the new data.

## Timing
- Read latency: grant in cycle N, `mem_re` in N+1, `*_rvalid`/`*_rdata` in N+2. Throughput is 1 access per cycle.
- Back-to-back grants to alternating owners return in the same order, one per cycle.
- Reset (async assert, sync-safe deassert): `mem_re`, `mem_we`, `mem_addr`, `mem_wdata`, both rvalids and rdatas = 0; owner pipeline = NONE; starvation counter = 0. `if_gnt`/`ls_gnt` = 0 while `async_rst_n`=0.
- Reset mid-operation drops all in-flight reads. No rvalid is ever produced for them.
- Simultaneous `flush` and IF response cycle: `if_rvalid` is suppressed that cycle.
- Simultaneous `if_req` and `ls_req` with counter below limit: LS is granted.

## Configuration
- `MEM_ARB_FAIRNESS_EN` defined:
  - A 4-bit counter increments on each LS grant while `if_req`=1.
  - It clears on any IF grant or when `if_req`=0.
  - When the counter equals `STARVE_LIMIT` and `if_req`=1 (and `flush`=0), IF is granted over LS.
- Not defined: strict LS priority. No counter is implemented, and `STARVE_LIMIT` is ignored.

## Structure
- `mem_arb_pkg`: `ADDR_W`=8, `DATA_W`=8, `owner_t` enum {`OWN_NONE`, `OWN_IF`, `OWN_LS`}.
- Sub-module `mem_arb_prio`: contains the grant decision and the starvation counter (the counter only under `MEM_ARB_FAIRNESS_EN`).
- `mem_arbiter` contains the command registers, the owner pipeline and response steering.

## Test plan
- Reset, then `if_req`=1 with `if_addr`=0x10, where RAM[0x10]=0xA5: `if_gnt`=1 in cycle 0, `mem_re`=1 with `mem_addr`=0x10 in cycle 1, `if_rvalid`=1 with `if_rdata`=0xA5 in cycle 2.
- `if_req` and `ls_req` (load 0x20, RAM=0x3C) in the same cycle: `ls_gnt` first with `ls_rdata`=0x3C two cycles later, then `if_gnt` the next cycle.
- Store 0x77 to 0x40, then load 0x40 back-to-back: `ls_rvalid` with 0x77, and no rvalid for the store.
- IF read granted, then `flush`=1 one cycle later: `if_rvalid` stays 0 throughout. A concurrent LS load still returns.
- With `MEM_ARB_FAIRNESS_EN`, `STARVE_LIMIT`=4, and `ls_req` plus `if_req` held: 4 `ls_gnt`, then 1 `if_gnt`, repeating. Without the macro, `if_gnt` is never asserted.
- Assert `async_rst_n`=0 while two reads are in flight: all outputs go to 0 immediately, and no rvalid appears after release.
